// File: rtl/mem_request_arbiter.sv
// Shares one memory controller between instruction fetch and load/store.
// LS-first priority with a starvation bound for IF; flush discards speculative results.
module mem_request_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        flush,
  input  logic        if_req_valid,
  input  logic [31:0] if_req_pc,
  output logic        if_done,
  output logic [31:0] if_inst,
  input  logic        ls_req_valid,
  input  logic        ls_req_wr,
  input  logic [2:0]  ls_req_len,
  input  logic [31:0] ls_req_addr,
  input  logic [31:0] ls_req_wdata,
  output logic        ls_done,
  output logic [31:0] ls_rdata,
  output logic        mc_start_query,
  output logic [31:0] mc_pc,
  input  logic        mc_finish_query,
  input  logic [31:0] mc_inst,
  output logic        mc_start_access,
  output logic        mc_rw,
  output logic [2:0]  mc_len,
  output logic [31:0] mc_addr,
  output logic [31:0] mc_wdata,
  input  logic        mc_finish_rw,
  input  logic [31:0] mc_load_data
);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_LS, RESP} state_t;

  localparam int CW_RAW = $clog2(STARVE_LIMIT + 1);
  localparam int CW     = (CW_RAW > 3) ? CW_RAW : 3;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic          discard;
  logic          ls_win;
  logic          if_win;

  // LS only loses the grant once IF has been passed over STARVE_LIMIT times.
  always_comb begin
    ls_win = ls_req_valid && (!if_req_valid || (starve_cnt < LIMIT));
    if_win = if_req_valid && !ls_win;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      starve_cnt      <= '0;
      discard         <= 1'b0;
      if_done         <= 1'b0;
      if_inst         <= '0;
      ls_done         <= 1'b0;
      ls_rdata        <= '0;
      mc_start_query  <= 1'b0;
      mc_pc           <= '0;
      mc_start_access <= 1'b0;
      mc_rw           <= 1'b0;
      mc_len          <= '0;
      mc_addr         <= '0;
      mc_wdata        <= '0;
    end else if (rdy) begin
      // Pulses only retire on an enabled edge so a stall can never swallow one.
      mc_start_query  <= 1'b0;
      mc_start_access <= 1'b0;
      if_done         <= 1'b0;
      ls_done         <= 1'b0;
      case (state)
        IDLE: begin
          if (flush) begin
            starve_cnt <= '0;
          end else if (ls_win) begin
            mc_rw           <= ls_req_wr;
            mc_len          <= ls_req_len;
            mc_addr         <= ls_req_addr;
            mc_wdata        <= ls_req_wdata;
            mc_start_access <= 1'b1;
            state           <= WAIT_LS;
            starve_cnt      <= if_req_valid ? starve_cnt + 1'b1 : '0;
          end else begin
            if (if_win) begin
              mc_pc          <= if_req_pc;
              mc_start_query <= 1'b1;
              state          <= WAIT_IF;
            end
            starve_cnt <= '0;
          end
        end
        WAIT_IF: begin
          if (mc_finish_query) begin
            state <= RESP;
            if (discard || flush) begin
              discard <= 1'b0;
            end else begin
              if_inst <= mc_inst;
              if_done <= 1'b1;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        WAIT_LS: begin
          if (mc_finish_rw) begin
            state <= RESP;
            if (!mc_rw && (discard || flush)) begin
              discard <= 1'b0;
            end else begin
              ls_done  <= 1'b1;
              ls_rdata <= mc_rw ? '0 : mc_load_data;
            end
          end else if (flush && !mc_rw) begin
            // Stores are committed state and always report completion.
            discard <= 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: cycle table plus multi-cycle corner sequences.
module tb_mem_request_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        flush = 1'b0;
  logic        if_req_valid = 1'b0;
  logic [31:0] if_req_pc = 32'h1000;
  logic        if_done;
  logic [31:0] if_inst;
  logic        ls_req_valid = 1'b0;
  logic        ls_req_wr = 1'b0;
  logic [2:0]  ls_req_len = 3'd4;
  logic [31:0] ls_req_addr = 32'h2000;
  logic [31:0] ls_req_wdata = 32'h0;
  logic        ls_done;
  logic [31:0] ls_rdata;
  logic        mc_start_query;
  logic [31:0] mc_pc;
  logic        mc_finish_query = 1'b0;
  logic [31:0] mc_inst = 32'h00A00093;
  logic        mc_start_access;
  logic        mc_rw;
  logic [2:0]  mc_len;
  logic [31:0] mc_addr;
  logic [31:0] mc_wdata;
  logic        mc_finish_rw = 1'b0;
  logic [31:0] mc_load_data = 32'h11223344;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_request_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .if_req_valid(if_req_valid), .if_req_pc(if_req_pc), .if_done(if_done), .if_inst(if_inst),
    .ls_req_valid(ls_req_valid), .ls_req_wr(ls_req_wr), .ls_req_len(ls_req_len),
    .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .mc_start_query(mc_start_query), .mc_pc(mc_pc), .mc_finish_query(mc_finish_query), .mc_inst(mc_inst),
    .mc_start_access(mc_start_access), .mc_rw(mc_rw), .mc_len(mc_len), .mc_addr(mc_addr),
    .mc_wdata(mc_wdata), .mc_finish_rw(mc_finish_rw), .mc_load_data(mc_load_data)
  );

  typedef struct {
    logic        rdy, flush, ifv, lsv, fq, frw;
    logic        sq, sa, ifd, lsd;
    logic [31:0] inst, rdata;
  } vec_t;

  localparam logic [31:0] I = 32'h00A00093;
  localparam logic [31:0] D = 32'h11223344;

  vec_t vt[22];

  function automatic vec_t row(logic [5:0] in_b, logic [3:0] out_b, logic [31:0] inst, logic [31:0] rdata);
    vec_t v;
    {v.rdy, v.flush, v.ifv, v.lsv, v.fq, v.frw} = in_b;
    {v.sq, v.sa, v.ifd, v.lsd} = out_b;
    v.inst  = inst;
    v.rdata = rdata;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Waits for the next grant, plays memory controller with a 2-cycle latency, checks the done pulse.
  task automatic serve(input logic exp_ls, input string nm);
    int n = 0;
    logic was_ls;
    while (!mc_start_access && !mc_start_query && n < 10) begin
      tick();
      n++;
    end
    chk({nm, "_grant_seen"}, 32'(n < 10), 32'd1);
    chk({nm, "_winner_ls"}, 32'(mc_start_access), 32'(exp_ls));
    was_ls = mc_start_access;
    tick();
    tick();
    if (was_ls) mc_finish_rw = 1'b1; else mc_finish_query = 1'b1;
    tick();
    mc_finish_rw = 1'b0;
    mc_finish_query = 1'b0;
    if (was_ls) chk({nm, "_ls_done"}, 32'(ls_done), 32'd1);
    else begin
      chk({nm, "_if_done"}, 32'(if_done), 32'd1);
      chk({nm, "_if_inst"}, if_inst, mc_inst);
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = row(6'b101000, 4'b1000, 0, 0);
    vt[1]  = row(6'b101000, 4'b0000, 0, 0);
    vt[2]  = row(6'b101000, 4'b0000, 0, 0);
    vt[3]  = row(6'b101000, 4'b0000, 0, 0);
    vt[4]  = row(6'b101010, 4'b0010, I, 0);
    vt[5]  = row(6'b101000, 4'b0000, I, 0);
    vt[6]  = row(6'b100000, 4'b0000, I, 0);
    vt[7]  = row(6'b101100, 4'b0100, I, 0);
    vt[8]  = row(6'b101100, 4'b0000, I, 0);
    vt[9]  = row(6'b101101, 4'b0001, I, D);
    vt[10] = row(6'b101100, 4'b0000, I, D);
    vt[11] = row(6'b101000, 4'b1000, I, D);
    vt[12] = row(6'b101011, 4'b0010, I, D);
    vt[13] = row(6'b100000, 4'b0000, I, D);
    vt[14] = row(6'b100011, 4'b0000, I, D);
    vt[15] = row(6'b001000, 4'b0000, I, D);
    vt[16] = row(6'b101000, 4'b1000, I, D);
    vt[17] = row(6'b101010, 4'b0010, I, D);
    vt[18] = row(6'b101000, 4'b0000, I, D);
    vt[19] = row(6'b100000, 4'b0000, I, D);
    vt[20] = row(6'b111100, 4'b0000, I, D);
    vt[21] = row(6'b100000, 4'b0000, I, D);

    // Reset state
    tick();
    tick();
    chk("rst_start_query", 32'(mc_start_query), 0);
    chk("rst_start_access", 32'(mc_start_access), 0);
    chk("rst_if_done", 32'(if_done), 0);
    chk("rst_ls_done", 32'(ls_done), 0);
    chk("rst_mc_len", 32'(mc_len), 0);
    #2 rst = 1'b0;
    tick();

    for (int i = 0; i < 22; i++) begin
      {rdy, flush, if_req_valid, ls_req_valid, mc_finish_query, mc_finish_rw} =
        {vt[i].rdy, vt[i].flush, vt[i].ifv, vt[i].lsv, vt[i].fq, vt[i].frw};
      tick();
      chk($sformatf("v%0d_start_query", i), 32'(mc_start_query), 32'(vt[i].sq));
      chk($sformatf("v%0d_start_access", i), 32'(mc_start_access), 32'(vt[i].sa));
      chk($sformatf("v%0d_if_done", i), 32'(if_done), 32'(vt[i].ifd));
      chk($sformatf("v%0d_ls_done", i), 32'(ls_done), 32'(vt[i].lsd));
      chk($sformatf("v%0d_if_inst", i), if_inst, vt[i].inst);
      chk($sformatf("v%0d_ls_rdata", i), ls_rdata, vt[i].rdata);
    end
    chk("tbl_mc_pc", mc_pc, 32'h1000);
    chk("tbl_mc_addr", mc_addr, 32'h2000);
    chk("tbl_mc_len", 32'(mc_len), 32'd4);
    chk("tbl_mc_rw", 32'(mc_rw), 32'd0);

    // Starvation: four LS grants, then IF; the counter restarts after IF wins
    if_req_valid = 1'b1;
    ls_req_valid = 1'b1;
    for (int g = 0; g < 10; g++) serve(g % 5 != 4, $sformatf("starve%0d", g));
    if_req_valid = 1'b0;
    ls_req_valid = 1'b0;
    tick();

    // Flush during WAIT_IF: result absorbed, arbiter grants again two edges after the finish
    if_req_valid = 1'b1;
    tick();
    chk("flif_grant", 32'(mc_start_query), 1);
    flush = 1'b1;
    if_req_valid = 1'b0;
    tick();
    flush = 1'b0;
    tick();
    mc_inst = 32'h0BAD0BAD;
    mc_finish_query = 1'b1;
    tick();
    mc_finish_query = 1'b0;
    chk("flif_no_done", 32'(if_done), 0);
    chk("flif_inst_kept", if_inst, I);
    ls_req_valid = 1'b1;
    ls_req_wr = 1'b0;
    ls_req_addr = 32'h3000;
    ls_req_len = 3'd2;
    tick();
    chk("flif_resp_no_grant", 32'(mc_start_access), 0);
    tick();
    chk("flld_grant", 32'(mc_start_access), 1);
    chk("flld_addr", mc_addr, 32'h3000);
    chk("flld_len", 32'(mc_len), 32'd2);

    // Flush during a load
    flush = 1'b1;
    ls_req_valid = 1'b0;
    tick();
    flush = 1'b0;
    mc_load_data = 32'h0000CAFE;
    mc_finish_rw = 1'b1;
    tick();
    mc_finish_rw = 1'b0;
    chk("flld_no_done", 32'(ls_done), 0);
    chk("flld_rdata_kept", ls_rdata, D);

    // Flush during a store (also coincident with its finish): store still completes
    ls_req_valid = 1'b1;
    ls_req_wr = 1'b1;
    ls_req_addr = 32'h4000;
    ls_req_len = 3'd4;
    ls_req_wdata = 32'hDEADBEEF;
    tick();
    tick();
    chk("flst_grant", 32'(mc_start_access), 1);
    chk("flst_rw", 32'(mc_rw), 1);
    chk("flst_wdata", mc_wdata, 32'hDEADBEEF);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    flush = 1'b1;
    mc_finish_rw = 1'b1;
    tick();
    flush = 1'b0;
    mc_finish_rw = 1'b0;
    ls_req_valid = 1'b0;
    chk("flst_done", 32'(ls_done), 1);
    chk("flst_rdata_zero", ls_rdata, 0);
    tick();
    chk("flst_done_clear", 32'(ls_done), 0);

    // Flush coincident with a fetch finish, then a clean fetch proves discard was cleared
    if_req_valid = 1'b1;
    tick();
    chk("flfin_grant", 32'(mc_start_query), 1);
    tick();
    mc_finish_query = 1'b1;
    flush = 1'b1;
    if_req_valid = 1'b0;
    tick();
    mc_finish_query = 1'b0;
    flush = 1'b0;
    chk("flfin_no_done", 32'(if_done), 0);
    tick();
    if_req_valid = 1'b1;
    tick();
    chk("clean_grant", 32'(mc_start_query), 1);
    tick();
    mc_inst = 32'h12345678;
    mc_finish_query = 1'b1;
    tick();
    mc_finish_query = 1'b0;
    if_req_valid = 1'b0;
    chk("clean_done", 32'(if_done), 1);
    chk("clean_inst", if_inst, 32'h12345678);
    tick();

    // rdy stall right after grant: start pulse stretches, one access only; done stretches too
    ls_req_valid = 1'b1;
    ls_req_wr = 1'b0;
    ls_req_addr = 32'h5000;
    ls_req_len = 3'd1;
    tick();
    chk("stall_grant", 32'(mc_start_access), 1);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("stall_hold%0d", k), 32'(mc_start_access), 1);
    end
    rdy = 1'b1;
    tick();
    chk("stall_clear", 32'(mc_start_access), 0);
    tick();
    chk("stall_single", 32'(mc_start_access), 0);
    mc_load_data = 32'h000000AB;
    mc_finish_rw = 1'b1;
    tick();
    mc_finish_rw = 1'b0;
    chk("stall_done", 32'(ls_done), 1);
    chk("stall_rdata", ls_rdata, 32'h000000AB);
    rdy = 1'b0;
    tick();
    chk("stall_done_hold", 32'(ls_done), 1);
    rdy = 1'b1;
    ls_req_valid = 1'b0;
    tick();
    chk("stall_done_clear", 32'(ls_done), 0);
    tick();

    // Asynchronous reset while in WAIT_LS, then a fresh fetch
    ls_req_valid = 1'b1;
    ls_req_wr = 1'b1;
    ls_req_addr = 32'h6000;
    ls_req_wdata = 32'h00000055;
    tick();
    chk("rstls_grant", 32'(mc_start_access), 1);
    tick();
    ls_req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rstls_addr", mc_addr, 0);
    chk("rstls_wdata", mc_wdata, 0);
    chk("rstls_rw", 32'(mc_rw), 0);
    chk("rstls_pc", mc_pc, 0);
    chk("rstls_if_inst", if_inst, 0);
    chk("rstls_ls_rdata", ls_rdata, 0);
    #2 rst = 1'b0;
    tick();
    if_req_valid = 1'b1;
    mc_inst = 32'hA5A5A5A5;
    serve(1'b0, "post_rst");
    chk("post_rst_pc", mc_pc, 32'h1000);
    if_req_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
